cache_ctrl: RTL
===============

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter: LINE_WORDS, 4, words per cache line; fixed, not overridable.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 Addr  in  16  CPU byte address; tag=Addr[15:11], index=Addr[10:3], word=Addr[2:1], Addr[0] must be 0.
REQ-005 DataIn  in  16  CPU store data.
REQ-006 Rd, Wr  in  1 each  CPU load/store request, sampled only in IDLE.
REQ-007 DataOut  out  16  load data, valid when Done=1.
REQ-008 Done, Stall, CacheHit, err  out  1 each  completion pulse, busy indication, hit-without-fill flag, request error pulse.
REQ-009 c_en, c_comp, c_write, c_valid_in  out  1 each  cache array control.
REQ-010 c_tag  out  5, c_index  out  8, c_word  out  2, c_data_in  out  16  cache array address/data.
REQ-011 c_hit, c_valid, c_dirty  in  1 each; c_tag_in  in  5; c_data_out  in  16  combinational cache array response.
REQ-012 m_rd, m_wr  out  1 each; m_addr  out  16; m_data_in  out  16  backing-memory request.
REQ-013 m_stall  in  1  request not accepted this cycle; m_rvalid  in  1, m_data_out  in  16  read return, in issue order, any latency >=1.

Function
REQ-014 States: IDLE, WB, ALLOC, RETRY; one state register, one-hot or binary.
REQ-015 IDLE, Rd xor Wr, Addr[0]=0: drive c_en=1, c_comp=1, c_write=Wr, c_data_in=DataIn, tag/index/word from Addr; latch Addr, DataIn, Rd/Wr.
REQ-016 IDLE hit (c_hit&c_valid): Done=1, CacheHit=1, DataOut=c_data_out same cycle, Stall=0, remain IDLE.
REQ-017 IDLE miss: Stall=1 from that cycle; next state WB if c_valid&c_dirty, else ALLOC; c_tag_in latched as victim tag.
REQ-018 IDLE, Rd&Wr or Addr[0]=1: err=1 one cycle, no cache or memory access, remain IDLE.
REQ-019 Rd/Wr outside IDLE ignored; Stall=1 in every non-IDLE state.
REQ-020 WB: beat k=0..3 drives c_en=1, c_comp=0, c_write=0, c_word=k; m_wr=1, m_addr={victim_tag,index,k,1'b0}, m_data_in=c_data_out; k advances only when m_stall=0; after beat 3 accepted -> ALLOC.
REQ-021 ALLOC: issue m_rd for words 0..3, m_addr={tag,index,k,1'b0}, one per cycle, advance on m_stall=0; m_rd=0 after 4 accepted.
REQ-022 ALLOC fill: each m_rvalid writes cache c_en=1, c_comp=0, c_write=1, c_valid_in=1, c_tag=tag, c_word=return count, c_data_in=m_data_out; issue and return may coincide.
REQ-023 4th m_rvalid -> RETRY; m_rvalid outside ALLOC ignored.
REQ-024 RETRY: repeat REQ-015 access from latched values; Done=1, CacheHit=0, DataOut=c_data_out, Stall=0; next IDLE.
REQ-025 Beat/return counters 2-bit, cleared on entry to WB and ALLOC; no wrap beyond 3.
REQ-026 All outputs not listed for a state are 0; m_addr, m_data_in, c_data_in 0 when unused.

Reset
REQ-027 rst=0 forces IDLE immediately, clears counters and latches, all outputs 0, including mid-WB/ALLOC.
REQ-028 Reset does not touch cache contents; partially filled line remains as written.
REQ-029 First request accepted on the first rising edge after rst deasserts.

Verification
REQ-030 Cold read 0x0810, m_stall=0, latency 2 -> 4 m_rd addr 0x0810..0x0816, 4 fills, Done in RETRY, CacheHit=0.
REQ-031 Read 0x0812 after REQ-030 -> Done and CacheHit same cycle, no memory traffic.
REQ-032 Write 0x0810 data 0xBEEF, then read 0x8810 (same index, tag differs) -> 4 m_wr to 0x0810..0x0816 with 0xBEEF at 0x0810, then 4 m_rd 0x8810..0x8816.
REQ-033 m_stall=1 for 3 cycles during WB beat 1 -> m_addr/m_data_in held, k unchanged, no beat lost.
REQ-034 rst=0 after 2nd m_rvalid -> outputs 0 asynchronously, IDLE; next read same line refills from word 0.
REQ-035 Rd=Wr=1, or Addr=0x0811 -> err pulse 1 cycle, no c_en/m_rd/m_wr, Done=0.

Source files
------------

// File: rtl/cache_ctrl.sv
// Blocking direct-mapped cache controller: 4-word lines, write-back and
// write-allocate, backed by a pipelined memory with in-order read returns.
module cache_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic        c_en,
    output logic        c_comp,
    output logic        c_write,
    output logic        c_valid_in,
    output logic [4:0]  c_tag,
    output logic [7:0]  c_index,
    output logic [1:0]  c_word,
    output logic [15:0] c_data_in,
    input  logic        c_hit,
    input  logic        c_valid,
    input  logic        c_dirty,
    input  logic [4:0]  c_tag_in,
    input  logic [15:0] c_data_out,
    output logic        m_rd,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [15:0] m_data_in,
    input  logic        m_stall,
    input  logic        m_rvalid,
    input  logic [15:0] m_data_out
);

    localparam int LINE_WORDS = 4;
    localparam logic [1:0] LAST = 2'(LINE_WORDS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WB    = 2'd1;
    localparam logic [1:0] S_ALLOC = 2'd2;
    localparam logic [1:0] S_RETRY = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:1] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic [4:0]  vtag_q, vtag_d;
    logic [1:0]  beat_q, beat_d;
    logic [1:0]  ret_q, ret_d;
    logic        iss_q, iss_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = wr_q;
        vtag_d     = vtag_q;
        beat_d     = beat_q;
        ret_d      = ret_q;
        iss_d      = iss_q;
        DataOut    = '0;
        Done       = 1'b0;
        Stall      = 1'b0;
        CacheHit   = 1'b0;
        err        = 1'b0;
        c_en       = 1'b0;
        c_comp     = 1'b0;
        c_write    = 1'b0;
        c_valid_in = 1'b0;
        c_tag      = '0;
        c_index    = '0;
        c_word     = '0;
        c_data_in  = '0;
        m_rd       = 1'b0;
        m_wr       = 1'b0;
        m_addr     = '0;
        m_data_in  = '0;
        // Outputs are gated by reset so they drop without waiting for a clock.
        if (rst) begin
            unique case (1'b1)
                (state_q == S_IDLE): begin
                    if ((Rd | Wr) && ((Rd & Wr) || Addr[0])) begin
                        err = 1'b1;
                    end else if (Rd ^ Wr) begin
                        c_en      = 1'b1;
                        c_comp    = 1'b1;
                        c_write   = Wr;
                        c_data_in = DataIn;
                        c_tag     = Addr[15:11];
                        c_index   = Addr[10:3];
                        c_word    = Addr[2:1];
                        addr_d    = Addr[15:1];
                        data_d    = DataIn;
                        wr_d      = Wr;
                        if (c_hit && c_valid) begin
                            Done     = 1'b1;
                            CacheHit = 1'b1;
                            DataOut  = c_data_out;
                        end else begin
                            Stall  = 1'b1;
                            vtag_d = c_tag_in;
                            beat_d = '0;
                            ret_d  = '0;
                            iss_d  = 1'b0;
                            state_d = (c_valid && c_dirty) ? S_WB : S_ALLOC;
                        end
                    end
                end
                (state_q == S_WB): begin
                    Stall     = 1'b1;
                    c_en      = 1'b1;
                    c_index   = addr_q[10:3];
                    c_word    = beat_q;
                    m_wr      = 1'b1;
                    m_addr    = {vtag_q, addr_q[10:3], beat_q, 1'b0};
                    m_data_in = c_data_out;
                    if (!m_stall) begin
                        if (beat_q == LAST) begin
                            beat_d  = '0;
                            ret_d   = '0;
                            iss_d   = 1'b0;
                            state_d = S_ALLOC;
                        end else begin
                            beat_d = beat_q + 2'd1;
                        end
                    end
                end
                (state_q == S_ALLOC): begin
                    Stall = 1'b1;
                    if (!iss_q) begin
                        m_rd   = 1'b1;
                        m_addr = {addr_q[15:3], beat_q, 1'b0};
                        if (!m_stall) begin
                            if (beat_q == LAST) iss_d = 1'b1;
                            else beat_d = beat_q + 2'd1;
                        end
                    end
                    // Returns arrive in issue order, so the count is the word.
                    if (m_rvalid) begin
                        c_en       = 1'b1;
                        c_write    = 1'b1;
                        c_valid_in = 1'b1;
                        c_tag      = addr_q[15:11];
                        c_index    = addr_q[10:3];
                        c_word     = ret_q;
                        c_data_in  = m_data_out;
                        if (ret_q == LAST) state_d = S_RETRY;
                        else ret_d = ret_q + 2'd1;
                    end
                end
                default: begin
                    c_en      = 1'b1;
                    c_comp    = 1'b1;
                    c_write   = wr_q;
                    c_data_in = data_q;
                    c_tag     = addr_q[15:11];
                    c_index   = addr_q[10:3];
                    c_word    = addr_q[2:1];
                    Done      = 1'b1;
                    DataOut   = c_data_out;
                    state_d   = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            vtag_q  <= '0;
            beat_q  <= '0;
            ret_q   <= '0;
            iss_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            vtag_q  <= vtag_d;
            beat_q  <= beat_d;
            ret_q   <= ret_d;
            iss_q   <= iss_d;
        end
    end

endmodule
